fancytimer_cmd_driver: RTL and testbench

- Upstream stage of the 1101-pattern fancy timer.
- Accepts a 4-bit delay command over a valid/ready handshake and serialises it onto the timer's `data` line: start pattern 1101, then delay[3:0] MSB first.
- Supervises the timer's `counting` and `done` outputs, then returns the `ack` the timer needs to re-arm.
- Reports completions and start-up timeouts to the command source.

---
 rtl/fancytimer_cmd_driver.sv | 160 ++++++++++++++++
 tb/tb_fancytimer_cmd_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fancytimer_cmd_driver.sv
// fancytimer_cmd_driver
//   Upstream command stage for the 1101-pattern fancy timer. Takes a 4-bit delay
//   command over a valid/ready handshake and shifts it onto the timer's serial
//   line as 1101 followed by delay[3:0] MSB first. It then watches the timer's
//   counting/done outputs and returns the ack the timer needs to re-arm.
//
// Ports
//   clk          rising-edge clock
//   resetn       synchronous active-low reset
//   cmd_valid    command present
//   cmd_delay    requested delay; the timer runs (cmd_delay+1)*1000 cycles
//   cmd_ready    driver can accept a command (IDLE only)
//   data         registered serial line to the timer
//   counting     timer is counting
//   done         timer has finished
//   ack          registered one-cycle pulse that re-arms the timer
//   busy         high in every state except IDLE
//   cmd_done     one-cycle pulse coincident with ack
//   err_timeout  one-cycle pulse when counting never rose after the frame
//   done_cnt     completed-command count, wraps modulo 2^CNT_W

module fancytimer_cmd_driver #(
    parameter int unsigned ACK_DELAY     = 0,
    parameter int unsigned START_TIMEOUT = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd_delay,
    output logic             cmd_ready,
    output logic             data,
    input  logic             counting,
    input  logic             done,
    output logic             ack,
    output logic             busy,
    output logic             cmd_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitCnt,
        StRun,
        StAckDly,
        StAck
    } state_e;

    localparam logic [3:0]       START_PAT = 4'b1101;
    // Last value of each wait counter before the terminal action fires.
    localparam logic [3:0]       TMO_LAST  = 4'(START_TIMEOUT - 1);
    localparam logic [3:0]       DLY_LAST  = 4'(ACK_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e     state;
    logic [3:0] delay_sr;
    logic [2:0] bit_idx;
    logic [3:0] tmo_cnt;
    logic [3:0] dly_cnt;

    assign cmd_ready = (state == StIdle);
    assign busy      = (state != StIdle);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= StIdle;
            data        <= 1'b0;
            ack         <= 1'b0;
            cmd_done    <= 1'b0;
            err_timeout <= 1'b0;
            done_cnt    <= '0;
            delay_sr    <= '0;
            bit_idx     <= '0;
            tmo_cnt     <= '0;
            dly_cnt     <= '0;
        end else begin
            // Pulses and the serial line default low; only SEND drives a 1 on data,
            // so the idle line can never mimic a start pattern.
            data        <= 1'b0;
            ack         <= 1'b0;
            cmd_done    <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        state    <= StSend;
                        bit_idx  <= 3'd0;
                        delay_sr <= cmd_delay;
                        data     <= START_PAT[3];
                    end
                end

                StSend: begin
                    // bit_idx names the bit currently on the line; load the next one.
                    if (bit_idx == 3'd7) begin
                        state   <= StWaitCnt;
                        tmo_cnt <= 4'd0;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx < 3'd3) begin
                            data <= START_PAT[2'd2 - bit_idx[1:0]];
                        end else begin
                            data     <= delay_sr[3];
                            delay_sr <= {delay_sr[2:0], 1'b0};
                        end
                    end
                end

                StWaitCnt: begin
                    if (counting) begin
                        state <= StRun;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= StIdle;
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end

                StRun: begin
                    // A dropped counting without done is tolerated; only done ends RUN.
                    if (done) begin
                        if (ACK_DELAY == 0) begin
                            state    <= StAck;
                            ack      <= 1'b1;
                            cmd_done <= 1'b1;
                            done_cnt <= done_cnt + CNT_ONE;
                        end else begin
                            state   <= StAckDly;
                            dly_cnt <= 4'd0;
                        end
                    end
                end

                StAckDly: begin
                    if (dly_cnt == DLY_LAST) begin
                        state    <= StAck;
                        ack      <= 1'b1;
                        cmd_done <= 1'b1;
                        done_cnt <= done_cnt + CNT_ONE;
                    end else begin
                        dly_cnt <= dly_cnt + 4'd1;
                    end
                end

                StAck: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fancytimer_cmd_driver.sv
// Directed bench for fancytimer_cmd_driver. Two instances share clock and reset:
// dut_a (ACK_DELAY=0, CNT_W=2) and dut_b (ACK_DELAY=3, CNT_W=8). The timer side
// (counting/done) is driven directly by the bench.

module tb_fancytimer_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic       a_cmd_valid, a_cmd_ready, a_data, a_counting, a_done;
    logic       a_ack, a_busy, a_cmd_done, a_err;
    logic [3:0] a_cmd_delay;
    logic [1:0] a_done_cnt;

    logic       b_cmd_valid, b_cmd_ready, b_data, b_counting, b_done;
    logic       b_ack, b_busy, b_cmd_done, b_err;
    logic [3:0] b_cmd_delay;
    logic [7:0] b_done_cnt;

    int checks = 0;
    int errors = 0;

    fancytimer_cmd_driver #(
        .ACK_DELAY    (0),
        .START_TIMEOUT(4),
        .CNT_W        (2)
    ) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (a_cmd_valid),
        .cmd_delay  (a_cmd_delay),
        .cmd_ready  (a_cmd_ready),
        .data       (a_data),
        .counting   (a_counting),
        .done       (a_done),
        .ack        (a_ack),
        .busy       (a_busy),
        .cmd_done   (a_cmd_done),
        .err_timeout(a_err),
        .done_cnt   (a_done_cnt)
    );

    fancytimer_cmd_driver #(
        .ACK_DELAY    (3),
        .START_TIMEOUT(4),
        .CNT_W        (8)
    ) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (b_cmd_valid),
        .cmd_delay  (b_cmd_delay),
        .cmd_ready  (b_cmd_ready),
        .data       (b_data),
        .counting   (b_counting),
        .done       (b_done),
        .ack        (b_ack),
        .busy       (b_busy),
        .cmd_done   (b_cmd_done),
        .err_timeout(b_err),
        .done_cnt   (b_done_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first SEND cycle; leaves in the first WAIT_CNT cycle.
    task automatic frame_a(input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            check("a_frame_bit", a_data, pat[7-i]);
            check("a_frame_ready", {a_cmd_ready, a_busy}, 2'b01);
            tick();
        end
        check("a_frame_tail", a_data, 1'b0);
    endtask

    task automatic frame_b(input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            check("b_frame_bit", b_data, pat[7-i]);
            check("b_frame_ready", {b_cmd_ready, b_busy}, 2'b01);
            tick();
        end
        check("b_frame_tail", b_data, 1'b0);
    endtask

    logic [1:0] exp_seq [5];

    initial begin
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        resetn      = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_delay = 4'h0; a_counting = 1'b0; a_done = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_delay = 4'h0; b_counting = 1'b0; b_done = 1'b0;
        tick();
        tick();

        // Reset state
        check("a_reset_outs", {a_data, a_ack, a_cmd_done, a_err, a_busy}, 5'b00000);
        check("a_reset_ready", a_cmd_ready, 1'b1);
        check("a_reset_cnt", a_done_cnt, 2'd0);
        check("b_reset_outs", {b_data, b_ack, b_cmd_done, b_err, b_busy}, 5'b00000);
        check("b_reset_cnt", b_done_cnt, 8'd0);
        resetn = 1'b1;
        tick();

        // Delay 5 on dut_a, ACK_DELAY=0, long run with a counting glitch
        a_cmd_delay = 4'h5;
        a_cmd_valid = 1'b1;
        check("t1_ready_idle", a_cmd_ready, 1'b1);
        tick();
        a_cmd_valid = 1'b0;
        frame_a(8'b1101_0101);
        a_counting = 1'b1;
        tick();
        for (int i = 0; i < 6000; i++) begin
            check("t1_run", {a_data, a_ack, a_busy, a_cmd_ready}, 4'b0010);
            if (i == 100) a_counting = 1'b0;
            if (i == 120) a_counting = 1'b1;
            tick();
        end
        a_counting = 1'b0;
        a_done     = 1'b1;
        check("t1_no_early_ack", a_ack, 1'b0);
        tick();
        check("t1_ack", {a_ack, a_cmd_done}, 2'b11);
        check("t1_cnt", a_done_cnt, 2'd1);
        check("t1_ready_in_ack", a_cmd_ready, 1'b0);
        a_done = 1'b0;
        tick();
        check("t1_after_ack", {a_ack, a_cmd_done, a_busy, a_cmd_ready}, 4'b0001);
        check("t1_cnt_hold", a_done_cnt, 2'd1);

        // Delay 0 on dut_b, ACK_DELAY=3: ack four cycles after done rises
        b_cmd_delay = 4'h0;
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        frame_b(8'b1101_0000);
        b_counting = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t2_run", {b_data, b_ack, b_busy}, 3'b001);
            tick();
        end
        b_counting = 1'b0;
        b_done     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_ack_wait", {b_ack, b_busy}, 2'b01);
            tick();
        end
        check("t2_ack", {b_ack, b_cmd_done}, 2'b11);
        check("t2_cnt", b_done_cnt, 8'd1);
        b_done = 1'b0;
        tick();
        check("t2_after_ack", {b_ack, b_cmd_done, b_busy, b_cmd_ready}, 4'b0001);

        // Start-up timeout on dut_b: counting never rises, done glitch ignored
        b_cmd_delay = 4'h3;
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        frame_b(8'b1101_0011);
        for (int i = 0; i < 4; i++) begin
            check("t3_wait", {b_err, b_ack, b_busy}, 3'b001);
            if (i == 1) b_done = 1'b1;
            if (i == 2) b_done = 1'b0;
            tick();
        end
        check("t3_err", {b_err, b_ack, b_busy, b_cmd_ready}, 4'b1001);
        check("t3_cnt", b_done_cnt, 8'd1);
        tick();
        check("t3_err_pulse", {b_err, b_ack, b_busy}, 3'b000);

        // Reset during SEND index 5 on dut_a
        a_cmd_delay = 4'h5;
        a_cmd_valid = 1'b1;
        tick();
        a_cmd_valid = 1'b0;
        repeat (5) tick();
        check("t4_idx5", a_data, 1'b1);
        resetn = 1'b0;
        tick();
        check("t4_abort", {a_data, a_busy, a_cmd_ready, a_ack, a_err}, 5'b00100);
        check("t4_cnt", a_done_cnt, 2'd0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_quiet", {a_data, a_busy}, 2'b00);
            tick();
        end

        // Five back-to-back commands on dut_a, CNT_W=2, cmd_valid held high
        a_cmd_delay = 4'h0;
        a_cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t5_ready_idle", a_cmd_ready, 1'b1);
            tick();
            frame_a(8'b1101_0000);
            a_counting = 1'b1;
            tick();
            a_counting = 1'b0;
            a_done     = 1'b1;
            check("t5_run", {a_ack, a_busy, a_cmd_ready}, 3'b010);
            tick();
            check("t5_ack", {a_ack, a_cmd_ready}, 2'b10);
            check("t5_cnt", a_done_cnt, exp_seq[k]);
            a_done = 1'b0;
            tick();
        end
        a_cmd_valid = 1'b0;
        check("t5_end_idle", {a_busy, a_cmd_ready}, 2'b01);
        tick();
        check("t5_final", {a_busy, a_data, a_done_cnt}, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
